adc_dac_loop_avg: RTL and testbench

- Parametrised successor of the single-shot ADC→calibrate→DAC loop.
- Acquires 2^LOG2_SAMPS consecutive ADC samples, box-car averages them, applies signed fixed-point ADC gain/offset calibration with saturation, then DAC gain/offset with clamp to DAC code range.
- Adds one-shot, continuous and raw modes, abort, BUSY/DONE handshake and sticky saturation flag.
- Sits between the ADC capture pins and the DAC B code output; REG_DATA feeds the GPIO readback path.

---
 rtl/adc_dac_loop_avg.sv | 198 +++++++++++++++++++
 tb/tb_adc_dac_loop_avg.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dac_loop_avg.sv
// Averaging ADC->calibrate->DAC loop: box-car averages 2^LOG2_SAMPS samples,
// applies ADC gain/offset with saturation, then DAC gain/offset with clamping.
module adc_dac_loop_avg #(
   parameter int FLOAT_WIDTH = 32,
   parameter int FRAC_BITS   = 16,
   parameter int ADC_WIDTH   = 12,
   parameter int DAC_WIDTH   = 14,
   parameter int LOG2_SAMPS  = 10
) (
   input  logic                     ADC_CLK,
   input  logic                     RST_N,
   input  logic [ADC_WIDTH-1:0]     ADC_DATA_IN,
   input  logic                     ENABLE,
   input  logic [1:0]               MODE,
   input  logic [4*FLOAT_WIDTH-1:0] CFG_IN,
   output logic [FLOAT_WIDTH-1:0]   REG_DATA,
   output logic [DAC_WIDTH-1:0]     DAC_CODE_OUT,
   output logic                     BUSY,
   output logic                     DONE,
   output logic                     SAT
);

   localparam int FW = FLOAT_WIDTH;
   localparam int AW = ADC_WIDTH + LOG2_SAMPS;
   localparam int PW = ADC_WIDTH + FLOAT_WIDTH;
   localparam int QW = 2 * FLOAT_WIDTH;
   localparam int CW = (LOG2_SAMPS > 0) ? LOG2_SAMPS : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'((64'd1 << LOG2_SAMPS) - 64'd1);

   localparam logic signed [FW-1:0] GAIN_ONE = FW'(64'd1 << FRAC_BITS);
   localparam logic signed [FW-1:0] F_MAX    = {1'b0, {(FW-1){1'b1}}};
   localparam logic signed [FW-1:0] F_MIN    = {1'b1, {(FW-1){1'b0}}};
   localparam logic signed [PW:0]   F_MAX_X  = (PW+1)'(F_MAX);
   localparam logic signed [PW:0]   F_MIN_X  = (PW+1)'(F_MIN);
   localparam logic signed [QW:0]   D_MAX_X  = (QW+1)'((64'd1 << DAC_WIDTH) - 64'd1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ACQ     = 3'd1;
   localparam logic [2:0] S_MUL     = 3'd2;
   localparam logic [2:0] S_ADC_CAL = 3'd3;
   localparam logic [2:0] S_DAC_CAL = 3'd4;

   logic [2:0]               state;
   logic [2:0]               state_next;
   logic                     en_q;
   logic                     en_d;
   logic                     start;
   logic                     cont_q;
   logic signed [FW-1:0]     adc_gain_q;
   logic signed [FW-1:0]     adc_off_q;
   logic signed [FW-1:0]     dac_gain_q;
   logic signed [FW-1:0]     dac_off_q;
   logic signed [AW-1:0]     acc;
   logic [CW-1:0]            cnt;
   logic signed [AW-1:0]     sample_ext;
   logic signed [ADC_WIDTH-1:0] avg;
   logic signed [PW-1:0]     prod_q;
   logic signed [PW:0]       adc_sum;
   logic signed [FW-1:0]     adc_val;
   logic                     adc_clip;
   logic                     adc_clip_q;
   logic signed [FW-1:0]     reg_q;
   logic signed [QW-1:0]     dac_prod;
   logic signed [QW:0]       dac_sum;
   logic [DAC_WIDTH-1:0]     dac_val;
   logic                     dac_clip;
   logic [DAC_WIDTH-1:0]     dac_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     sat_q;

   assign start      = (state == S_IDLE) && en_q && !en_d;
   assign sample_ext = AW'(signed'(ADC_DATA_IN));

   // Next-state logic; a low registered ENABLE aborts any stage before DAC_CAL.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:    if (start) state_next = S_ACQ;
         S_ACQ:     if (!en_q) state_next = S_IDLE;
                    else if (cnt == CNT_LAST) state_next = S_MUL;
         S_MUL:     state_next = en_q ? S_ADC_CAL : S_IDLE;
         S_ADC_CAL: state_next = en_q ? S_DAC_CAL : S_IDLE;
         S_DAC_CAL: state_next = (cont_q && en_q) ? S_ACQ : S_IDLE;
         default:   state_next = S_IDLE;
      endcase
   end

   // ADC stage: floor average, fixed-point offset add, saturate to signed FW.
   always_comb begin
      avg      = ADC_WIDTH'(acc >>> LOG2_SAMPS);
      adc_sum  = (PW+1)'(prod_q >>> FRAC_BITS) + (PW+1)'(adc_off_q);
      adc_val  = adc_sum[FW-1:0];
      adc_clip = 1'b0;
      if (adc_sum > F_MAX_X) begin
         adc_val  = F_MAX;
         adc_clip = 1'b1;
      end else if (adc_sum < F_MIN_X) begin
         adc_val  = F_MIN;
         adc_clip = 1'b1;
      end
   end

   // DAC stage: scale the calibrated value and clamp into the unsigned code range.
   always_comb begin
      dac_prod = QW'(reg_q) * QW'(dac_gain_q);
      dac_sum  = (QW+1)'(dac_prod >>> FRAC_BITS) + (QW+1)'(dac_off_q);
      dac_val  = dac_sum[DAC_WIDTH-1:0];
      dac_clip = 1'b0;
      if (dac_sum < 0) begin
         dac_val  = '0;
         dac_clip = 1'b1;
      end else if (dac_sum > D_MAX_X) begin
         dac_val  = {DAC_WIDTH{1'b1}};
         dac_clip = 1'b1;
      end
   end

   // The ENABLE history resets high so a level held through reset never reads as a new edge.
   always_ff @(posedge ADC_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         en_q       <= 1'b1;
         en_d       <= 1'b1;
         cont_q     <= 1'b0;
         adc_gain_q <= '0;
         adc_off_q  <= '0;
         dac_gain_q <= '0;
         dac_off_q  <= '0;
         acc        <= '0;
         cnt        <= '0;
         prod_q     <= '0;
         adc_clip_q <= 1'b0;
         reg_q      <= '0;
         dac_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sat_q      <= 1'b0;
      end else begin
         en_q   <= ENABLE;
         en_d   <= en_q;
         state  <= state_next;
         busy_q <= (state_next != S_IDLE);
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  cont_q     <= (MODE == 2'd1);
                  adc_gain_q <= (MODE == 2'd2) ? GAIN_ONE : signed'(CFG_IN[FW-1:0]);
                  adc_off_q  <= (MODE == 2'd2) ? '0 : signed'(CFG_IN[2*FW-1:FW]);
                  dac_gain_q <= (MODE == 2'd2) ? GAIN_ONE : signed'(CFG_IN[3*FW-1:2*FW]);
                  dac_off_q  <= (MODE == 2'd2) ? '0 : signed'(CFG_IN[4*FW-1:3*FW]);
                  acc        <= '0;
                  cnt        <= '0;
                  adc_clip_q <= 1'b0;
                  sat_q      <= 1'b0;
               end
            end
            S_ACQ: begin
               if (!en_q) begin
                  cnt <= '0;
               end else begin
                  acc <= acc + sample_ext;
                  cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
               end
            end
            S_MUL: begin
               if (en_q) prod_q <= PW'(avg) * PW'(adc_gain_q);
            end
            S_ADC_CAL: begin
               if (en_q) begin
                  reg_q      <= adc_val;
                  adc_clip_q <= adc_clip;
               end
            end
            S_DAC_CAL: begin
               dac_q  <= dac_val;
               sat_q  <= adc_clip_q | dac_clip;
               done_q <= 1'b1;
               if (cont_q && en_q) begin
                  acc        <= '0;
                  cnt        <= '0;
                  adc_clip_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign REG_DATA     = reg_q;
   assign DAC_CODE_OUT = dac_q;
   assign BUSY         = busy_q;
   assign DONE         = done_q;
   assign SAT          = sat_q;

endmodule

// File: tb/tb_adc_dac_loop_avg.sv
// Directed bench for adc_dac_loop_avg with four-sample averaging; expected
// values are hand-computed from the calibration arithmetic.
module tb_adc_dac_loop_avg;

   logic         adcClk;
   logic         rstN;
   logic [11:0]  adcData;
   logic         enable;
   logic [1:0]   mode;
   logic [127:0] cfgIn;
   logic [31:0]  regData;
   logic [13:0]  dacCode;
   logic         busy;
   logic         done;
   logic         sat;

   int checks   = 0;
   int failures = 0;

   adc_dac_loop_avg #(
      .FLOAT_WIDTH(32),
      .FRAC_BITS(16),
      .ADC_WIDTH(12),
      .DAC_WIDTH(14),
      .LOG2_SAMPS(2)
   ) dut (
      .ADC_CLK(adcClk),
      .RST_N(rstN),
      .ADC_DATA_IN(adcData),
      .ENABLE(enable),
      .MODE(mode),
      .CFG_IN(cfgIn),
      .REG_DATA(regData),
      .DAC_CODE_OUT(dacCode),
      .BUSY(busy),
      .DONE(done),
      .SAT(sat)
   );

   initial adcClk = 1'b0;
   always #5 adcClk = ~adcClk;

   function automatic logic [127:0] packCfg(input logic [31:0] adcGain, input logic [31:0] adcOff,
                                            input logic [31:0] dacGain, input logic [31:0] dacOff);
      return {dacOff, dacGain, adcOff, adcGain};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // One acquisition: fresh ENABLE edge, four samples fed one per ACQ cycle,
   // then the result is captured on the DONE cycle.
   task automatic applyStimulus(input logic [1:0] runMode, input logic [127:0] cfg,
                                input logic [11:0] s0, input logic [11:0] s1,
                                input logic [11:0] s2, input logic [11:0] s3,
                                output logic [31:0] regEarly, output logic [31:0] regObs,
                                output logic [13:0] dacObs, output logic satObs);
      logic [11:0] smp [4];
      int waitCnt;
      int busyCycles;
      int doneCycles;
      smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
      enable = 1'b0;
      repeat (3) @(negedge adcClk);
      mode   = runMode;
      cfgIn  = cfg;
      enable = 1'b1;
      waitCnt = 0;
      @(negedge adcClk);
      while (!busy && waitCnt < 10) begin
         @(negedge adcClk);
         waitCnt++;
      end
      checkOutput("busy_start", 64'(busy), 64'd1);
      busyCycles = 0;
      doneCycles = 0;
      for (int i = 0; i < 4; i++) begin
         adcData = smp[i];
         busyCycles += int'(busy);
         doneCycles += int'(done);
         @(negedge adcClk);
      end
      for (int i = 0; i < 3; i++) begin
         busyCycles += int'(busy);
         doneCycles += int'(done);
         regEarly = regData;
         @(negedge adcClk);
      end
      checkOutput("done_timing", 64'(done), 64'd1);
      regObs = regData;
      dacObs = dacCode;
      satObs = sat;
      busyCycles += int'(busy);
      doneCycles += int'(done);
      @(negedge adcClk);
      doneCycles += int'(done);
      checkOutput("busy_cycles", 64'(busyCycles), 64'd7);
      checkOutput("done_pulses", 64'(doneCycles), 64'd1);
   endtask

   logic [31:0] regEarly;
   logic [31:0] regObs;
   logic [13:0] dacObs;
   logic        satObs;
   logic [127:0] cfgUnity;
   int tick;
   int doneN;
   int firstT;
   int secondT;
   int extra;

   initial begin
      rstN    = 1'b0;
      enable  = 1'b0;
      adcData = '0;
      mode    = 2'd0;
      cfgIn   = '0;
      cfgUnity = packCfg(32'h0001_0000, 32'd0, 32'h0001_0000, 32'd8192);
      repeat (2) @(negedge adcClk);
      checkOutput("rst_reg", 64'(regData), 64'd0);
      checkOutput("rst_dac", 64'(dacCode), 64'd0);
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_sat", 64'(sat), 64'd0);
      rstN = 1'b1;

      // Constant 100 through unity gains and a mid-scale DAC offset.
      applyStimulus(2'd0, cfgUnity, 12'd100, 12'd100, 12'd100, 12'd100, regEarly, regObs, dacObs, satObs);
      checkOutput("t1_reg_early", 64'(regEarly), 64'd100);
      checkOutput("t1_reg", 64'(regObs), 64'd100);
      checkOutput("t1_dac", 64'(dacObs), 64'd8292);
      checkOutput("t1_sat", 64'(satObs), 64'd0);

      // Sum -1 floors to an average of -1.
      applyStimulus(2'd0, cfgUnity, 12'd1, 12'd2, 12'd3, 12'hFF9, regEarly, regObs, dacObs, satObs);
      checkOutput("t2_reg", 64'(regObs), 64'h0000_0000_FFFF_FFFF);
      checkOutput("t2_dac", 64'(dacObs), 64'd8191);
      checkOutput("t2_sat", 64'(satObs), 64'd0);

      // Gain 2.5, offset -20 on -2048 gives -5140; the DAC clamps at zero.
      applyStimulus(2'd0, packCfg(32'h0002_8000, 32'hFFFF_FFEC, 32'h0001_0000, 32'd0),
                    12'h800, 12'h800, 12'h800, 12'h800, regEarly, regObs, dacObs, satObs);
      checkOutput("t3_reg", 64'(regObs), 64'h0000_0000_FFFF_EBEC);
      checkOutput("t3_dac", 64'(dacObs), 64'd0);
      checkOutput("t3_sat", 64'(satObs), 64'd1);

      // Raw mode ignores every calibration word.
      applyStimulus(2'd2, packCfg(32'd0, 32'd1234, 32'h0003_0000, 32'd8192),
                    12'd500, 12'd500, 12'd500, 12'd500, regEarly, regObs, dacObs, satObs);
      checkOutput("t4_reg", 64'(regObs), 64'd500);
      checkOutput("t4_dac", 64'(dacObs), 64'd500);
      checkOutput("t4_sat", 64'(satObs), 64'd0);

      // 2047 * 0x7FFFFFFF >> 16 = 67076095; the large offset pushes it past full scale.
      applyStimulus(2'd0, packCfg(32'h7FFF_FFFF, 32'h7FFF_0000, 32'h0001_0000, 32'd0),
                    12'd2047, 12'd2047, 12'd2047, 12'd2047, regEarly, regObs, dacObs, satObs);
      checkOutput("t5_reg", 64'(regObs), 64'h0000_0000_7FFF_FFFF);
      checkOutput("t5_dac", 64'(dacObs), 64'd16383);
      checkOutput("t5_sat", 64'(satObs), 64'd1);

      // Mode 3 behaves as one-shot, and SAT clears at the new start.
      applyStimulus(2'd3, cfgUnity, 12'd100, 12'd100, 12'd100, 12'd100, regEarly, regObs, dacObs, satObs);
      checkOutput("t6_reg", 64'(regObs), 64'd100);
      checkOutput("t6_dac", 64'(dacObs), 64'd8292);
      checkOutput("t6_sat", 64'(satObs), 64'd0);

      // Continuous mode: two results seven cycles apart, then drop ENABLE mid-ACQ.
      enable = 1'b0;
      repeat (3) @(negedge adcClk);
      mode    = 2'd1;
      cfgIn   = cfgUnity;
      adcData = 12'd100;
      enable  = 1'b1;
      tick = 0; doneN = 0; firstT = -1; secondT = -1;
      while (doneN < 2 && tick < 40) begin
         @(negedge adcClk);
         tick++;
         if (done) begin
            doneN++;
            if (doneN == 1) firstT = tick;
            else secondT = tick;
         end
      end
      checkOutput("cont_done_count", 64'(doneN), 64'd2);
      checkOutput("cont_period", 64'(secondT - firstT), 64'd7);
      checkOutput("cont_busy_on_done", 64'(busy), 64'd1);
      checkOutput("cont_reg", 64'(regData), 64'd100);
      checkOutput("cont_dac", 64'(dacCode), 64'd8292);
      checkOutput("cont_sat", 64'(sat), 64'd0);
      @(negedge adcClk);
      enable = 1'b0;
      @(negedge adcClk);
      checkOutput("abort_busy_hold", 64'(busy), 64'd1);
      @(negedge adcClk);
      checkOutput("abort_busy_fall", 64'(busy), 64'd0);
      extra = 0;
      repeat (20) begin
         @(negedge adcClk);
         extra += int'(done);
      end
      checkOutput("abort_no_done", 64'(extra), 64'd0);
      checkOutput("abort_reg_kept", 64'(regData), 64'd100);
      checkOutput("abort_dac_kept", 64'(dacCode), 64'd8292);

      // Reset during ACQ, then a held-high ENABLE must not start a run.
      mode   = 2'd0;
      enable = 1'b1;
      tick = 0;
      @(negedge adcClk);
      while (!busy && tick < 10) begin
         @(negedge adcClk);
         tick++;
      end
      checkOutput("rst_test_busy", 64'(busy), 64'd1);
      @(negedge adcClk);
      rstN = 1'b0;
      #1;
      checkOutput("midrst_reg", 64'(regData), 64'd0);
      checkOutput("midrst_dac", 64'(dacCode), 64'd0);
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      @(negedge adcClk);
      rstN = 1'b1;
      extra = 0;
      repeat (15) begin
         @(negedge adcClk);
         extra += int'(busy);
      end
      checkOutput("held_enable_no_start", 64'(extra), 64'd0);
      applyStimulus(2'd0, cfgUnity, 12'd100, 12'd100, 12'd100, 12'd100, regEarly, regObs, dacObs, satObs);
      checkOutput("post_rst_reg", 64'(regObs), 64'd100);
      checkOutput("post_rst_dac", 64'(dacObs), 64'd8292);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
